ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Sits between the processor's two memory requesters (instruction fetch, data load/store) and the single-port synchronous RAM.
- Arbits one access per cycle round-robin, pipelines the RAM's 1-cycle read latency and returns read data to the owning requester.
- Optionally zero-fills the whole RAM after reset before granting any access.

Parameters:
WORDSIZE, 32, data word width; must match the RAM.
WORDS, 256, RAM depth; address width ADDRW = $clog2(WORDS).
CLEAR_ON_RESET, 1, 1 = sweep-write zeros to every address after reset; 0 = go straight to RUN.

Ports:
Clock  in  1  single clock, rising edge.
Reset  in  1  asynchronous, active-high.
B_Anfrage  in  1  fetch read request.
B_Adresse  in  ADDRW  fetch address.
B_Bereit  out  1  fetch request accepted this cycle.
B_DatenGueltig  out  1  fetch read data valid (1-cycle pulse).
B_Daten  out  WORDSIZE  fetch read data.
D_Anfrage  in  1  data request.
D_Schreiben  in  1  1 = write, 0 = read.
D_Adresse  in  ADDRW  data address.
D_DatenRein  in  WORDSIZE  write data.
D_Bereit  out  1  data request accepted this cycle.
D_DatenGueltig  out  1  data read data valid (1-cycle pulse, reads only).
D_Daten  out  WORDSIZE  data read data.
RAM_SchreibenAn  out  1  to RAM write enable.
RAM_Adresse  out  ADDRW  to RAM address.
RAM_DatenRein  out  WORDSIZE  to RAM write data.
RAM_DatenRaus  in  WORDSIZE  from RAM; registered read data, valid 1 cycle after a read cycle.

Behaviour:
- Clocking: single clock Clock. Reset is asynchronous and active-high.
- State machine: START -> INIT (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0); INIT -> RUN; RUN stays in RUN.
- Reset values: state=START, clear counter=0, RR pointer=DATA (so fetch wins the first tie), both valid flags 0, both Daten hold registers 0.
- Outputs while in START or while Reset is high: Bereit 0, DatenGueltig 0, RAM_SchreibenAn 0, RAM_Adresse 0, RAM_DatenRein 0.
- START: lasts exactly 1 cycle; no RAM access.
- INIT: RAM_SchreibenAn=1, RAM_Adresse=counter, RAM_DatenRein=0. Counter increments every cycle; on counter==WORDS-1 go to RUN, counter back to 0. Exactly WORDS write cycles. Both Bereit held at 0 throughout.
- RUN grant (combinational, same cycle):
  - only one Anfrage high -> that requester wins;
  - both high -> the requester not granted most recently wins;
  - winner's Bereit=1 and its address/data/write drive the RAM ports that cycle;
  - RR pointer updates on every grant;
  - loser's Bereit=0 and it must hold its request stable until accepted.
- No request in RUN: RAM_SchreibenAn=0, RAM_Adresse=0, RAM_DatenRein=0. The resulting idle read is harmless and raises no valid flag.
- Fetch is always a read; RAM_DatenRein is driven 0 on fetch grants.
- Write, accepted in cycle T: RAM written at the end of T; no DatenGueltig pulse.
- Read, accepted in cycle T:
  - owner's DatenGueltig=1 in cycle T+1 only;
  - owner's Daten = RAM_DatenRaus during T+1, captured into the owner's hold register at the end of T+1;
  - Daten presents the hold value whenever DatenGueltig=0;
  - the other requester's Daten and DatenGueltig are unaffected.
- Throughput: one grant per cycle; back-to-back reads give back-to-back valid pulses. A grant in T+1 is allowed while T's response is returning.
- Read after write to the same address in consecutive cycles returns the new data.
- Reset asserted mid-operation: the in-flight response is dropped (DatenGueltig forced 0) and INIT restarts at address 0.

Decomposition:
- Shared package: state encoding (START, INIT, RUN) and requester IDs (REQ_FETCH=0, REQ_DATA=1).
- ADDRW is derived locally from WORDS.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with a registered last-grant pointer.

Test Plan:
- CLEAR_ON_RESET=1, WORDS=256; release Reset -> 1 START cycle, then exactly 256 RAM write cycles with data 0 at addresses 0..255; Bereit stays 0 until RUN.
- RUN, D write addr 5 data 0xDEADBEEF, then D read addr 5 next cycle -> D_DatenGueltig pulses 2 cycles after the write with D_Daten=0xDEADBEEF; D_Daten holds the value afterwards.
- Both request continuously (B addr 1, D read addr 2) -> grants alternate B, D, B, D starting with B; valid pulses alternate one cycle later with correct data.
- Only B requests for 4 cycles (addresses 0..3) -> B_Bereit=1 every cycle and 4 consecutive B_DatenGueltig pulses in address order; D outputs unchanged.
- Assert Reset the cycle after a D read grant -> D_DatenGueltig never pulses; all outputs at reset values immediately; INIT restarts at address 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared definitions for the RAM arbiter: controller state encoding and the
// requester identifiers used to index grant vectors and the round-robin
// pointer.
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

    // Controller states: one START cycle, optional zero-fill sweep, then RUN.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Requester IDs; also the bit positions inside a 2-bit grant/request vector.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a registered last-grant pointer.
// A single requester always wins; on a tie the requester that was not
// granted most recently wins. The pointer resets to REQ_DATA so the fetch
// side wins the very first tie.
//
// Ports:
//   Clock   in   rising-edge clock
//   Reset   in   asynchronous active-high reset
//   enable  in   1 = grants allowed this cycle
//   req     in   [1:0] request vector, bit REQ_FETCH / bit REQ_DATA
//   grant   out  [1:0] one-hot (or zero) grant, valid in the same cycle
// ---------------------------------------------------------------------------
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last;

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = (last == REQ_DATA) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last <= REQ_DATA;
        end else if (grant != 2'b00) begin
            last <= grant[REQ_DATA] ? REQ_DATA : REQ_FETCH;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Connects the instruction-fetch and data requesters to one single-port
// synchronous RAM. One access is granted per cycle (round-robin on ties);
// read data returns one cycle after the grant to the requester that owned
// the read, and is held afterwards. Optionally zero-fills the RAM after reset.
//
// Ports:
//   Clock, Reset                     clock / async active-high reset
//   B_Anfrage, B_Adresse             fetch read request and address
//   B_Bereit                         fetch request accepted this cycle
//   B_DatenGueltig, B_Daten          fetch read data pulse and data
//   D_Anfrage, D_Schreiben           data request, 1 = write
//   D_Adresse, D_DatenRein           data address and write data
//   D_Bereit                         data request accepted this cycle
//   D_DatenGueltig, D_Daten          data read data pulse and data
//   RAM_SchreibenAn, RAM_Adresse,
//   RAM_DatenRein                    RAM control, address, write data
//   RAM_DatenRaus                    RAM registered read data
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WORDSIZE       = 32,
    parameter int WORDS          = 256,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDRW         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                B_Anfrage,
    input  logic [ADDRW-1:0]    B_Adresse,
    output logic                B_Bereit,
    output logic                B_DatenGueltig,
    output logic [WORDSIZE-1:0] B_Daten,
    input  logic                D_Anfrage,
    input  logic                D_Schreiben,
    input  logic [ADDRW-1:0]    D_Adresse,
    input  logic [WORDSIZE-1:0] D_DatenRein,
    output logic                D_Bereit,
    output logic                D_DatenGueltig,
    output logic [WORDSIZE-1:0] D_Daten,
    output logic                RAM_SchreibenAn,
    output logic [ADDRW-1:0]    RAM_Adresse,
    output logic [WORDSIZE-1:0] RAM_DatenRein,
    input  logic [WORDSIZE-1:0] RAM_DatenRaus
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(WORDS - 1);

    state_t              state, state_next;
    logic [ADDRW-1:0]    clr_cnt;
    logic [1:0]          grant;
    logic                b_pend, d_pend;     // read issued last cycle, data arriving now
    logic [WORDSIZE-1:0] b_hold, d_hold;

    // -----------------------------------------------------------------------
    // Arbitration: grants only exist in RUN, so START/INIT/reset keep both
    // Bereit low without extra gating.
    // -----------------------------------------------------------------------
    rr_arbiter2 u_rr (
        .Clock  (Clock),
        .Reset  (Reset),
        .enable (state == ST_RUN),
        .req    ({D_Anfrage, B_Anfrage}),
        .grant  (grant)
    );

    assign B_Bereit = grant[REQ_FETCH];
    assign D_Bereit = grant[REQ_DATA];

    // -----------------------------------------------------------------------
    // Controller FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_START;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_START: state_next = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            ST_INIT:  if (clr_cnt == LAST_ADDR) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_START;
        endcase
    end

    // Sweep counter: wraps back to 0 on the last address so a later reset
    // and a completed sweep both leave it at 0.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clr_cnt <= '0;
        end else if (state == ST_INIT) begin
            clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // RAM port mux. Idle RUN cycles and START drive all zeros; the resulting
    // read of address 0 is ignored because no pending flag is raised.
    // -----------------------------------------------------------------------
    always_comb begin
        RAM_SchreibenAn = 1'b0;
        RAM_Adresse     = '0;
        RAM_DatenRein   = '0;
        case (state)
            ST_INIT: begin
                RAM_SchreibenAn = 1'b1;
                RAM_Adresse     = clr_cnt;
            end
            ST_RUN: begin
                if (grant[REQ_FETCH]) begin
                    RAM_Adresse = B_Adresse;
                end else if (grant[REQ_DATA]) begin
                    RAM_SchreibenAn = D_Schreiben;
                    RAM_Adresse     = D_Adresse;
                    RAM_DatenRein   = D_DatenRein;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Read return path: the RAM answers one cycle after the read grant, so
    // the owner is remembered for one cycle and its data is captured into a
    // hold register at the end of that response cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            b_pend <= 1'b0;
            d_pend <= 1'b0;
            b_hold <= '0;
            d_hold <= '0;
        end else begin
            b_pend <= grant[REQ_FETCH];
            d_pend <= grant[REQ_DATA] & ~D_Schreiben;
            if (b_pend) b_hold <= RAM_DatenRaus;
            if (d_pend) d_hold <= RAM_DatenRaus;
        end
    end

    assign B_DatenGueltig = b_pend;
    assign D_DatenGueltig = d_pend;
    assign B_Daten        = b_pend ? RAM_DatenRaus : b_hold;
    assign D_Daten        = d_pend ? RAM_DatenRaus : d_hold;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Bench for ram_arbiter (WORDSIZE=32, WORDS=256, CLEAR_ON_RESET=1) with a
// behavioural synchronous RAM. Expected read data is pushed onto a queue at
// grant time from a reference memory image and popped when the response
// cycle arrives.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int WS    = 32;
    localparam int WORDS = 256;
    localparam int AW    = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          B_Anfrage;
    logic [AW-1:0] B_Adresse;
    logic          B_Bereit, B_DatenGueltig;
    logic [WS-1:0] B_Daten;
    logic          D_Anfrage, D_Schreiben;
    logic [AW-1:0] D_Adresse;
    logic [WS-1:0] D_DatenRein;
    logic          D_Bereit, D_DatenGueltig;
    logic [WS-1:0] D_Daten;
    logic          RAM_SchreibenAn;
    logic [AW-1:0] RAM_Adresse;
    logic [WS-1:0] RAM_DatenRein;
    logic [WS-1:0] RAM_DatenRaus;

    int n_cmp = 0;
    int n_bad = 0;

    ram_arbiter #(.WORDSIZE(WS), .WORDS(WORDS), .CLEAR_ON_RESET(1)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .B_Anfrage       (B_Anfrage),
        .B_Adresse       (B_Adresse),
        .B_Bereit        (B_Bereit),
        .B_DatenGueltig  (B_DatenGueltig),
        .B_Daten         (B_Daten),
        .D_Anfrage       (D_Anfrage),
        .D_Schreiben     (D_Schreiben),
        .D_Adresse       (D_Adresse),
        .D_DatenRein     (D_DatenRein),
        .D_Bereit        (D_Bereit),
        .D_DatenGueltig  (D_DatenGueltig),
        .D_Daten         (D_Daten),
        .RAM_SchreibenAn (RAM_SchreibenAn),
        .RAM_Adresse     (RAM_Adresse),
        .RAM_DatenRein   (RAM_DatenRein),
        .RAM_DatenRaus   (RAM_DatenRaus)
    );

    always #5 Clock = ~Clock;

    // Behavioural single-port RAM with registered read data.
    logic [WS-1:0] mem [WORDS];
    always @(posedge Clock) begin
        if (RAM_SchreibenAn) mem[RAM_Adresse] <= RAM_DatenRein;
        RAM_DatenRaus <= mem[RAM_Adresse];
    end

    // Reference model state.
    typedef struct {
        logic          owner;   // 0 = fetch, 1 = data
        logic [WS-1:0] data;
    } resp_t;

    resp_t         sb[$];
    logic [WS-1:0] ref_mem [WORDS];
    logic          tb_last;      // last granted requester
    logic [WS-1:0] b_hold_exp, d_hold_exp;

    task automatic model_reset();
        sb.delete();
        tb_last    = 1'b1;
        b_hold_exp = '0;
        d_hold_exp = '0;
    endtask

    // One RUN cycle: drive at posedge+1, check at the following negedge,
    // update the model, advance to the next posedge+1.
    task automatic run_cycle(input logic br, input logic [AW-1:0] ba,
                             input logic dr, input logic dw,
                             input logic [AW-1:0] da, input logic [WS-1:0] dd,
                             input string tag,
                             output logic gb, output logic gd);
        logic          exp_we;
        logic [AW-1:0] exp_a;
        logic [WS-1:0] exp_d;
        logic          have;
        resp_t         r;
        logic          ebv, edv;
        logic [WS-1:0] ebd, edd;

        B_Anfrage = br; B_Adresse = ba;
        D_Anfrage = dr; D_Schreiben = dw; D_Adresse = da; D_DatenRein = dd;

        if (br && dr) begin
            gb = (tb_last == 1'b1);
            gd = !gb;
        end else begin
            gb = br;
            gd = dr;
        end
        exp_we = gd && dw;
        exp_a  = gb ? ba : (gd ? da : '0);
        exp_d  = (gd && !gb) ? dd : '0;

        have = (sb.size() > 0);
        r.owner = 1'b0;
        r.data  = '0;
        if (have) r = sb.pop_front();
        ebv = have && (r.owner == 1'b0);
        edv = have && (r.owner == 1'b1);
        ebd = ebv ? r.data : b_hold_exp;
        edd = edv ? r.data : d_hold_exp;

        @(negedge Clock);
        n_cmp++;
        if ({B_Bereit, D_Bereit} !== {gb, gd}) begin
            n_bad++;
            $display("FAIL %s grant: got B=%b D=%b want B=%b D=%b", tag, B_Bereit, D_Bereit, gb, gd);
        end
        n_cmp++;
        if ({RAM_SchreibenAn, RAM_Adresse, RAM_DatenRein} !== {exp_we, exp_a, exp_d}) begin
            n_bad++;
            $display("FAIL %s ram_port: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                     tag, RAM_SchreibenAn, RAM_Adresse, RAM_DatenRein, exp_we, exp_a, exp_d);
        end
        n_cmp++;
        if ({B_DatenGueltig, D_DatenGueltig} !== {ebv, edv}) begin
            n_bad++;
            $display("FAIL %s valid: got B=%b D=%b want B=%b D=%b", tag, B_DatenGueltig, D_DatenGueltig, ebv, edv);
        end
        n_cmp++;
        if (B_Daten !== ebd) begin
            n_bad++;
            $display("FAIL %s B_Daten: got %h want %h", tag, B_Daten, ebd);
        end
        n_cmp++;
        if (D_Daten !== edd) begin
            n_bad++;
            $display("FAIL %s D_Daten: got %h want %h", tag, D_Daten, edd);
        end

        b_hold_exp = ebd;
        d_hold_exp = edd;
        if (gb) begin
            r.owner = 1'b0; r.data = ref_mem[ba]; sb.push_back(r);
            tb_last = 1'b0;
        end else if (gd) begin
            if (dw) ref_mem[da] = dd;
            else begin
                r.owner = 1'b1; r.data = ref_mem[da]; sb.push_back(r);
            end
            tb_last = 1'b1;
        end

        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input string tag);
        logic gb, gd;
        run_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, tag, gb, gd);
    endtask

    task automatic dwrite(input logic [AW-1:0] a, input logic [WS-1:0] d, input string tag);
        logic gb, gd;
        run_cycle(1'b0, '0, 1'b1, 1'b1, a, d, tag, gb, gd);
    endtask

    // Outputs while Reset is high must all be at their reset values.
    task automatic test_reset(input string tag);
        n_cmp++;
        if ({B_Bereit, D_Bereit, B_DatenGueltig, D_DatenGueltig, RAM_SchreibenAn} !== 5'b0 ||
            RAM_Adresse !== '0 || RAM_DatenRein !== '0 || B_Daten !== '0 || D_Daten !== '0) begin
            n_bad++;
            $display("FAIL %s reset_outputs: got rdy=%b%b vld=%b%b we=%b a=%0d d=%h bd=%h dd=%h want all 0",
                     tag, B_Bereit, D_Bereit, B_DatenGueltig, D_DatenGueltig, RAM_SchreibenAn,
                     RAM_Adresse, RAM_DatenRein, B_Daten, D_Daten);
        end
    endtask

    // Called at posedge+1 right after Reset falls: START then 256 clear writes.
    task automatic test_init(input string tag);
        B_Anfrage = 1'b1; B_Adresse = 8'd7;
        D_Anfrage = 1'b1; D_Schreiben = 1'b0; D_Adresse = 8'd9; D_DatenRein = 32'hFFFF_FFFF;
        @(negedge Clock);
        n_cmp++;
        if ({B_Bereit, D_Bereit, B_DatenGueltig, D_DatenGueltig, RAM_SchreibenAn} !== 5'b0 ||
            RAM_Adresse !== '0 || RAM_DatenRein !== '0) begin
            n_bad++;
            $display("FAIL %s start: got rdy=%b%b vld=%b%b we=%b a=%0d d=%h want all 0",
                     tag, B_Bereit, D_Bereit, B_DatenGueltig, D_DatenGueltig,
                     RAM_SchreibenAn, RAM_Adresse, RAM_DatenRein);
        end
        @(posedge Clock); #1;
        for (int i = 0; i < WORDS; i++) begin
            if (i == WORDS - 1) begin
                B_Anfrage = 1'b0;
                D_Anfrage = 1'b0;
            end
            @(negedge Clock);
            n_cmp++;
            if (RAM_SchreibenAn !== 1'b1 || RAM_Adresse !== AW'(i) || RAM_DatenRein !== '0 ||
                {B_Bereit, D_Bereit, B_DatenGueltig, D_DatenGueltig} !== 4'b0) begin
                n_bad++;
                $display("FAIL %s clear[%0d]: got we=%b a=%0d d=%h rdy=%b%b vld=%b%b want we=1 a=%0d d=0 rdy=00 vld=00",
                         tag, i, RAM_SchreibenAn, RAM_Adresse, RAM_DatenRein,
                         B_Bereit, D_Bereit, B_DatenGueltig, D_DatenGueltig, i);
            end
            @(posedge Clock); #1;
        end
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        model_reset();
    endtask

    task automatic test_write_read();
        logic gb, gd;
        dwrite(8'd5, 32'hDEADBEEF, "wr5");
        run_cycle(1'b0, '0, 1'b1, 1'b0, 8'd5, '0, "rd5", gb, gd);
        idle("rd5_resp");
        idle("rd5_hold");
        // Address 6 was cleared by the sweep (RAM was preloaded non-zero).
        run_cycle(1'b0, '0, 1'b1, 1'b0, 8'd6, '0, "rd6_zero", gb, gd);
        idle("rd6_resp");
    endtask

    task automatic test_alternate();
        logic gb, gd;
        dwrite(8'd1, 32'h1111_1111, "alt_wr1");
        dwrite(8'd2, 32'h2222_2222, "alt_wr2");
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 8'd1, 1'b1, 1'b0, 8'd2, '0, $sformatf("alt%0d", i), gb, gd);
        end
        idle("alt_tail");
    endtask

    task automatic test_fetch_only();
        logic gb, gd;
        dwrite(8'd0, 32'hA000_0000, "fo_wr0");
        dwrite(8'd3, 32'hA000_0003, "fo_wr3");
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, AW'(i), 1'b0, 1'b0, '0, '0, $sformatf("fo%0d", i), gb, gd);
        end
        idle("fo_tail");
        idle("fo_hold");
    endtask

    // Random mix; a refused requester keeps its request stable.
    task automatic test_back_to_back();
        logic gb, gd;
        logic b_r = 1'b0, d_r = 1'b0, d_w = 1'b0;
        logic b_wait = 1'b0, d_wait = 1'b0;
        logic [AW-1:0] b_a = '0, d_a = '0;
        logic [WS-1:0] d_d = '0;
        for (int i = 0; i < 60; i++) begin
            if (!b_wait) begin
                b_r = 1'($urandom_range(0, 1));
                b_a = AW'($urandom_range(0, 7));
            end
            if (!d_wait) begin
                d_r = 1'($urandom_range(0, 1));
                d_w = 1'($urandom_range(0, 1));
                d_a = AW'($urandom_range(0, 7));
                d_d = $urandom;
            end
            run_cycle(b_r, b_a, d_r, d_w, d_a, d_d, $sformatf("b2b%0d", i), gb, gd);
            b_wait = b_r && !gb;
            d_wait = d_r && !gd;
        end
        idle("b2b_tail");
    endtask

    task automatic test_reset_mid();
        logic gb, gd;
        run_cycle(1'b0, '0, 1'b1, 1'b0, 8'd5, '0, "mid_rd", gb, gd);
        Reset = 1'b1;
        B_Anfrage = 1'b0;
        D_Anfrage = 1'b0;
        model_reset();
        #1;
        test_reset("mid_reset");
        @(posedge Clock); #1;
        Reset = 1'b0;
        test_init("reinit");
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hC0DE_0000 | i;
        RAM_DatenRaus = '0;
        Reset = 1'b1;
        B_Anfrage = 1'b0; B_Adresse = '0;
        D_Anfrage = 1'b0; D_Schreiben = 1'b0; D_Adresse = '0; D_DatenRein = '0;
        model_reset();
        #2;
        test_reset("por");
        @(posedge Clock); #1;
        Reset = 1'b0;
        test_init("init");
        test_write_read();
        test_alternate();
        test_fetch_only();
        test_back_to_back();
        test_reset_mid();
        test_write_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
